// File: rtl/mult_div_pkg.sv
// Shared constants for the iterative multiply/divide unit.
// Holds FSM state codes, iteration count and Booth step encodings.
package mult_div_pkg;

    localparam int MD_DATA_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MULT = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_FIN  = 2'd3;

    typedef enum logic [1:0] {
        BOOTH_NOP0 = 2'b00,
        BOOTH_ADD  = 2'b01,
        BOOTH_SUB  = 2'b10,
        BOOTH_NOP1 = 2'b11
    } booth_e;

endpackage

// File: rtl/mult_div_booth_step.sv
// One radix-2 Booth iteration: add/sub multiplicand into the upper
// field, then arithmetic shift of the whole accumulator by one.
module mult_div_booth_step
    import mult_div_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic [2*DATA_W+1:0] acc,
    input  logic [DATA_W:0]     mcand,
    output logic [2*DATA_W+1:0] acc_nxt
);

    logic [DATA_W:0] upper;
    logic [DATA_W:0] sum;

    always_comb begin
        upper = acc[2*DATA_W+1:DATA_W+1];
        sum   = upper;
        case (booth_e'(acc[1:0]))
            BOOTH_ADD: sum = upper + mcand;
            BOOTH_SUB: sum = upper - mcand;
            default:   sum = upper;
        endcase
        acc_nxt = {sum[DATA_W], sum, acc[DATA_W:1]};
    end

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (Booth) / divide (restoring) unit, 33 cycles.
// Optional MULT_DIV_UNSIGNED_EN adds unsigned_op for multu/divu.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic              unsigned_op,
`endif
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    localparam int ACC_W = 2*DATA_W + 2;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [DATA_W:0]   mcand;
    logic              corr;
    logic              is_div;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic              neg_q;
    logic              neg_r;
    logic              uns_in;
    logic              a_neg;
    logic              b_neg;

`ifdef MULT_DIV_UNSIGNED_EN
    assign uns_in = unsigned_op;
`else
    assign uns_in = 1'b0;
`endif

    assign a_neg = ~uns_in & a_in[DATA_W-1];
    assign b_neg = ~uns_in & b_in[DATA_W-1];

    mult_div_booth_step #(
        .DATA_W (DATA_W)
    ) u_booth (
        .acc     (acc),
        .mcand   (mcand),
        .acc_nxt (acc_nxt)
    );

    // Restoring step; the subtract is exact whenever it is kept.
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] rem_sub;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;

    always_comb begin
        div_shift = {rem, quo[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, dvsr};
        rem_sub   = div_shift[DATA_W-1:0] - dvsr;
        rem_nxt   = div_ge ? rem_sub : div_shift[DATA_W-1:0];
        quo_nxt   = {quo[DATA_W-2:0], div_ge};
    end

    // Unsigned multiply runs Booth on b as signed; add a<<32 back if b[31].
    logic [DATA_W-1:0] mul_hi;
    logic [DATA_W-1:0] mul_lo;

    always_comb begin
        mul_lo = acc[DATA_W:1];
        mul_hi = acc[2*DATA_W:DATA_W+1];
        if (corr) begin
            mul_hi = mul_hi + mcand[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            corr     <= 1'b0;
            is_div   <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_mult) begin
                        mcand  <= {a_neg, a_in};
                        acc    <= {{(DATA_W+1){1'b0}}, b_in, 1'b0};
                        corr   <= uns_in & b_in[DATA_W-1];
                        is_div <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_MULT;
                    end else if (start_div && b_in != '0) begin
                        quo    <= a_neg ? -a_in : a_in;
                        dvsr   <= b_neg ? -b_in : b_in;
                        rem    <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        is_div <= 1'b1;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_DIV;
                    end else if (start_div) begin
                        div_zero <= 1'b1;
                    end
                end
                ST_MULT: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_FIN;
                    end
                end
                ST_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_FIN;
                    end
                end
                default: begin
                    if (is_div) begin
                        lo_out <= neg_q ? -quo : quo;
                        hi_out <= neg_r ? -rem : rem;
                    end else begin
                        lo_out <= mul_lo;
                        hi_out <= mul_hi;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Randomized self-checking bench for mult_div against a plain
// arithmetic reference model (signed multiply/divide on longint).
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_div #(
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
`ifdef MULT_DIV_UNSIGNED_EN
        .unsigned_op(1'b0),
`endif
        .a_in       (a_in),
        .b_in       (b_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input bit div,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa = longint'(int'(a));
        longint sb = longint'(int'(b));
        longint p;
        longint q;
        longint r;
        if (!div) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // hz: cycle after start at which a stray start pulse is injected
    task automatic run_op(input string tag, input bit div,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hz);
        logic [63:0] exp;
        int lat;
        exp = ref_op(div, a, b);
        start_mult = !div;
        start_div  = div;
        a_in = a;
        b_in = b;
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        check({tag, "_busy0"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == hz) begin
                start_mult = 1'b1;
                start_div  = 1'b1;
                b_in = 32'd3;
            end
            tick();
            start_mult = 1'b0;
            start_div  = 1'b0;
            lat++;
            if (lat == 32) check({tag, "_busy32"}, 64'(busy), 64'd1);
        end
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_busyfin"}, 64'(busy), 64'd0);
        check({tag, "_res"}, {hi_out, lo_out}, exp);
        tick();
        check({tag, "_done1"}, 64'(done), 64'd0);
    endtask

    task automatic run_dz(input logic [31:0] a);
        logic [63:0] prev;
        int dn;
        prev = {hi_out, lo_out};
        start_div = 1'b1;
        a_in = a;
        b_in = 32'd0;
        tick();
        start_div = 1'b0;
        check("dz_pulse", 64'(div_zero), 64'd1);
        check("dz_busy", 64'(busy), 64'd0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn++;
            tick();
            if (i == 0) check("dz_drop", 64'(div_zero), 64'd0);
        end
        check("dz_nodone", 64'(dn), 64'd0);
        check("dz_hold", {hi_out, lo_out}, prev);
    endtask

    initial begin
        int dn;
        logic [31:0] ra;
        logic [31:0] rb;
        bit rd;
        reset = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) tick();
        check("rst", {hi_out, lo_out}, 64'd0);
        check("rst_ctl", 64'({busy, done, div_zero}), 64'd0);
        reset = 1'b1;
        tick();

        run_op("m_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
        run_op("m_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
        run_op("m_min", 1'b0, 32'h8000_0000, 32'h8000_0000, -1);
        run_op("d_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("d_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("d_big", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, -1);
        run_dz(32'd55);
        run_op("d_hz", 1'b1, 32'd1000, 32'hFFFF_FFF9, 5);
        run_op("m_hz", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 12);

        for (int i = 0; i < 30; i++) begin
            rd = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = $urandom_range(0, 7) - 32'd3;
            if (rd && rb == 32'd0) run_dz(ra);
            else run_op("rnd", rd, ra, rb, -1);
        end

        start_mult = 1'b1;
        a_in = 32'd9;
        b_in = 32'd9;
        tick();
        start_mult = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_res", {hi_out, lo_out}, 64'd0);
        tick();
        reset = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) dn++;
        end
        check("rst_mid_nodone", 64'(dn), 64'd0);
        run_op("m_post", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
